// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, NOP encoding and IF/ID squash FSM.
package pipeline_pkg;

   localparam int          DATA_W_DEF        = 32;
   localparam logic [31:0] NOP_WORD_DEF      = 32'h0000_0000;
   localparam int          FLUSH_BUBBLES_MIN = 1;
   localparam int          FLUSH_BUBBLES_MAX = 7;
   localparam int          BUB_CNT_W         = 3;

   typedef enum logic {
      IFID_RUN    = 1'b0,
      IFID_SQUASH = 1'b1
   } ifid_state_e;

endpackage

// File: rtl/ifid_perf_counter.sv
// Free-running wrapping event counter with increment enable.
module ifid_perf_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         IncEn_i,
   output logic [W-1:0] Count_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (IncEn_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign Count_o = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall hold, multi-cycle flush squash and NOP fill.
// Optional IFID_PERF_CNT_EN adds fetched/stalled/squashed event counters.
module if_id_stage
   import pipeline_pkg::*;
#(
   parameter int                DATA_W        = DATA_W_DEF,
   parameter int                FLUSH_BUBBLES = 1,
   parameter logic [DATA_W-1:0] NOP_WORD      = DATA_W'(NOP_WORD_DEF)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Stall,
   input  logic              Flush,
   input  logic [DATA_W-1:0] InstrIn,
   input  logic [DATA_W-1:0] IncPCIn,
   output logic [DATA_W-1:0] InstrOut,
   output logic [DATA_W-1:0] IncPCOut,
   output logic              ValidOut,
`ifdef IFID_PERF_CNT_EN
   output logic [31:0]       CntFetched,
   output logic [31:0]       CntStalled,
   output logic [31:0]       CntSquashed,
`endif
   output logic              Squashing
);

   if (FLUSH_BUBBLES < FLUSH_BUBBLES_MIN ||
       FLUSH_BUBBLES > FLUSH_BUBBLES_MAX) begin : g_bad_fb
      $error("if_id_stage: FLUSH_BUBBLES must be 1..7");
   end

   localparam bit MULTI_BUB = (FLUSH_BUBBLES > 1);
   localparam logic [BUB_CNT_W-1:0] BUB_RELOAD =
      BUB_CNT_W'(FLUSH_BUBBLES - 1);

   ifid_state_e          state_q, state_d;
   logic [BUB_CNT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]    instr_q, instr_d;
   logic [DATA_W-1:0]    pc_q, pc_d;
   logic                 valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (Flush) begin
         instr_d = NOP_WORD;
         pc_d    = IncPCIn;
         valid_d = 1'b0;
         if (MULTI_BUB) begin
            state_d = IFID_SQUASH;
            cnt_d   = BUB_RELOAD;
         end else begin
            state_d = IFID_RUN;
            cnt_d   = '0;
         end
      end else if (Stall) begin
         // Hold everything; a stall never consumes a bubble.
         state_d = state_q;
      end else if (state_q == IFID_SQUASH) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
         cnt_d   = cnt_q - 1'b1;
         if (cnt_q == BUB_CNT_W'(1)) state_d = IFID_RUN;
      end else begin
         instr_d = InstrIn;
         pc_d    = IncPCIn;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IFID_RUN;
         cnt_q   <= '0;
         instr_q <= NOP_WORD;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign InstrOut  = instr_q;
   assign IncPCOut  = pc_q;
   assign ValidOut  = valid_q;
   assign Squashing = (state_q == IFID_SQUASH);

`ifdef IFID_PERF_CNT_EN
   logic fetch_en, stall_en, squash_en;

   assign fetch_en  = !Flush && !Stall && (state_q == IFID_RUN);
   assign stall_en  = !Flush && Stall;
   assign squash_en = Flush || (!Stall && (state_q == IFID_SQUASH));

   ifid_perf_counter #(.W(32)) u_cnt_fetched (
      .CLK     (CLK),
      .RST     (RST),
      .IncEn_i (fetch_en),
      .Count_o (CntFetched)
   );

   ifid_perf_counter #(.W(32)) u_cnt_stalled (
      .CLK     (CLK),
      .RST     (RST),
      .IncEn_i (stall_en),
      .Count_o (CntStalled)
   );

   ifid_perf_counter #(.W(32)) u_cnt_squashed (
      .CLK     (CLK),
      .RST     (RST),
      .IncEn_i (squash_en),
      .Count_o (CntSquashed)
   );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench: three IF/ID instances (FLUSH_BUBBLES=1,2,3) share one stimulus.
module tb_if_id_stage;

   localparam int N = 3;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic CLK = 1'b0;
   logic RST, Stall, Flush;
   logic [31:0] InstrIn, IncPCIn;

   logic [N-1:0][31:0] instr_o, pc_o;
   logic [N-1:0]       valid_o, sq_o;
`ifdef IFID_PERF_CNT_EN
   logic [N-1:0][31:0] cf_o, cs_o, cq_o;
`endif

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < N; g++) begin : g_dut
      if_id_stage #(
         .DATA_W        (32),
         .FLUSH_BUBBLES (g + 1),
         .NOP_WORD      (NOP)
      ) u_dut (
         .CLK         (CLK),
         .RST         (RST),
         .Stall       (Stall),
         .Flush       (Flush),
         .InstrIn     (InstrIn),
         .IncPCIn     (IncPCIn),
         .InstrOut    (instr_o[g]),
         .IncPCOut    (pc_o[g]),
         .ValidOut    (valid_o[g]),
`ifdef IFID_PERF_CNT_EN
         .CntFetched  (cf_o[g]),
         .CntStalled  (cs_o[g]),
         .CntSquashed (cq_o[g]),
`endif
         .Squashing   (sq_o[g])
      );
   end

   typedef struct {
      logic [N-1:0][31:0] instr;
      logic [N-1:0][31:0] pc;
      logic [N-1:0]       valid;
      logic [N-1:0]       sq;
      logic [N-1:0]       pck;
`ifdef IFID_PERF_CNT_EN
      logic [N-1:0][31:0] cf, cs, cq;
`endif
   } exp_t;

   exp_t q[$];

   // Reference model: what decode should see, plus bubbles still owed.
   logic [31:0] m_instr[N];
   logic [31:0] m_pc[N];
   logic        m_valid[N];
   logic        m_pck[N];
   int          m_owed[N];
`ifdef IFID_PERF_CNT_EN
   logic [31:0] m_cf[N], m_cs[N], m_cq[N];
`endif

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s fb=%0d got=%h exp=%h @%0t",
                  nm, idx + 1, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit stall, input bit flush,
                       input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      RST = rst; Stall = stall; Flush = flush;
      InstrIn = ins; IncPCIn = pc;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            m_instr[i] = NOP; m_pc[i] = '0; m_valid[i] = 1'b0;
            m_owed[i] = 0; m_pck[i] = 1'b1;
`ifdef IFID_PERF_CNT_EN
            m_cf[i] = '0; m_cs[i] = '0; m_cq[i] = '0;
`endif
         end else if (flush) begin
            // Flush itself is bubble one; FLUSH_BUBBLES = i+1.
            m_instr[i] = NOP; m_pc[i] = pc; m_valid[i] = 1'b0;
            m_owed[i] = i; m_pck[i] = 1'b1;
`ifdef IFID_PERF_CNT_EN
            m_cq[i] = m_cq[i] + 1;
`endif
         end else if (stall) begin
`ifdef IFID_PERF_CNT_EN
            m_cs[i] = m_cs[i] + 1;
`endif
         end else if (m_owed[i] > 0) begin
            m_instr[i] = NOP; m_valid[i] = 1'b0;
            m_owed[i] = m_owed[i] - 1; m_pck[i] = 1'b0;
`ifdef IFID_PERF_CNT_EN
            m_cq[i] = m_cq[i] + 1;
`endif
         end else begin
            m_instr[i] = ins; m_pc[i] = pc; m_valid[i] = 1'b1;
            m_pck[i] = 1'b1;
`ifdef IFID_PERF_CNT_EN
            m_cf[i] = m_cf[i] + 1;
`endif
         end
         e.instr[i] = m_instr[i];
         e.pc[i]    = m_pc[i];
         e.valid[i] = m_valid[i];
         e.pck[i]   = m_pck[i];
         e.sq[i]    = (m_owed[i] > 0);
`ifdef IFID_PERF_CNT_EN
         e.cf[i] = m_cf[i]; e.cs[i] = m_cs[i]; e.cq[i] = m_cq[i];
`endif
      end
      q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < N; i++) begin
            chk("instr", i, instr_o[i], e.instr[i]);
            chk("valid", i, {31'd0, valid_o[i]}, {31'd0, e.valid[i]});
            chk("squashing", i, {31'd0, sq_o[i]}, {31'd0, e.sq[i]});
            if (e.pck[i]) chk("incpc", i, pc_o[i], e.pc[i]);
`ifdef IFID_PERF_CNT_EN
            chk("cnt_fetched", i, cf_o[i], e.cf[i]);
            chk("cnt_stalled", i, cs_o[i], e.cs[i]);
            chk("cnt_squashed", i, cq_o[i], e.cq[i]);
`endif
         end
      end
   end

   initial begin
      logic [31:0] pcv;
      pcv = 32'd0;
      step(1, 0, 0, 32'h1111_1111, 32'd9);
      step(1, 1, 1, 32'h2222_2222, 32'd9);
      step(0, 0, 0, 32'h2010_0005, 32'd1);
      step(0, 0, 0, 32'h0230_8820, 32'd2);
      for (int k = 0; k < 3; k++)
         step(0, 1, 0, $urandom, $urandom);
      step(0, 0, 0, 32'hA5A5_0003, 32'd3);
      step(0, 0, 1, 32'hDEAD_BEEF, 32'd4);
      for (int k = 0; k < 4; k++)
         step(0, 0, 0, $urandom, 32'd5 + k);
      step(0, 1, 1, 32'hBAD0_0001, 32'd20);
      step(0, 1, 0, 32'hBAD0_0002, 32'd21);
      step(0, 1, 0, 32'hBAD0_0003, 32'd22);
      for (int k = 0; k < 4; k++)
         step(0, 0, 0, $urandom, 32'd23 + k);
      step(0, 0, 1, 32'hBAD0_0004, 32'd30);
      step(1, 1, 1, 32'hBAD0_0005, 32'd31);
      step(0, 0, 0, 32'h1234_5678, 32'd32);
      step(0, 0, 0, 32'h9ABC_DEF0, 32'd33);
      // Event-counter scenario on the FLUSH_BUBBLES=2 instance.
      step(1, 0, 0, '0, '0);
      for (int k = 0; k < 10; k++) step(0, 0, 0, $urandom, 32'd40 + k);
      for (int k = 0; k < 4; k++)  step(0, 1, 0, $urandom, $urandom);
      step(0, 0, 1, $urandom, 32'd60);
      step(0, 0, 0, $urandom, 32'd61);
`ifdef IFID_PERF_CNT_EN
      chk("perf_fetched_10", 1, cf_o[1], 32'd10);
      chk("perf_stalled_4", 1, cs_o[1], 32'd4);
      chk("perf_squashed_2", 1, cq_o[1], 32'd2);
`endif
      for (int k = 0; k < 400; k++) begin
         pcv = pcv + 1;
         step($urandom_range(99) < 2, $urandom_range(99) < 25,
              $urandom_range(99) < 10, $urandom, pcv);
      end
      step(0, 0, 0, $urandom, pcv + 1);
      @(negedge CLK);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register sitting directly downstream of the program counter and the instruction memory.
- Each cycle it captures the fetched instruction word and its PC+1 and presents them to the decode stage with a valid flag.
- Implements stall hold, branch-flush squash with a programmable bubble count, and NOP injection.
- Squash sequencing is a small FSM plus down-counter.

Parameters:
- DATA_W, 32, width of instruction and PC words.
- FLUSH_BUBBLES, 1, number of cycles, 1..7, for which fetched words are squashed after a Flush pulse.
- NOP_WORD, 32'h0000_0000, word driven on InstrOut when the stage holds no valid instruction.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- Stall  in  1  hazard-unit hold; same signal that freezes the PC.
- Flush  in  1  taken branch/jump (PCsrc) resolved this cycle; wrong-path fetch must be killed.
- InstrIn  in  DATA_W  instruction memory read data for the current PC (combinational from PC).
- IncPCIn  in  DATA_W  PC+1 belonging to InstrIn, same cycle.
- InstrOut  out  DATA_W  registered instruction to decode.
- IncPCOut  out  DATA_W  registered PC+1 to decode.
- ValidOut  out  1  InstrOut is a real instruction; 0 means bubble.
- Squashing  out  1  high while the FSM is in SQUASH (debug/hazard visibility).

Behaviour:
- Reset: synchronous; outputs take these values on the first rising edge with RST=1.
  - InstrOut=NOP_WORD, IncPCOut=0, ValidOut=0, Squashing=0.
  - FSM=RUN, bubble counter=0.
  - RST has priority over all inputs, including mid-squash and mid-stall.
- FSM states: RUN, SQUASH.
- Per-edge priority: RST > Flush > Stall > normal capture.
- Flush=1, any state, Stall ignored:
  - Register loads InstrOut=NOP_WORD, IncPCOut=IncPCIn, ValidOut=0.
  - If FLUSH_BUBBLES>1: go to SQUASH, counter=FLUSH_BUBBLES-1. Otherwise stay/return to RUN.
- SQUASH, Flush=0, Stall=0:
  - Load NOP_WORD with ValidOut=0 and decrement the counter.
  - When the counter reaches 0 the state returns to RUN on that same edge.
- SQUASH, Stall=1: hold the register and the counter. Stall does not consume bubbles.
- RUN, Stall=1: InstrOut, IncPCOut and ValidOut all hold their values unchanged.
- RUN, Stall=0, Flush=0: InstrOut<=InstrIn, IncPCOut<=IncPCIn, ValidOut<=1.
- Latency: exactly one cycle from InstrIn to InstrOut when unstalled.
- A Flush arriving while already in SQUASH reloads the counter; it does not add to it.
- Squashing = (state==SQUASH). It is registered and changes only at the clock edge.
- No arithmetic is done on IncPCIn; it is a pass-through, with no wrap handling required.
- FLUSH_BUBBLES outside 1..7 is illegal. Elaboration fails via a generate-time check.

Optional Feature:
- IFID_PERF_CNT_EN
- Defined: adds three 32-bit output ports CntFetched, CntStalled and CntSquashed.
  - CntFetched increments on each edge where ValidOut is loaded with 1.
  - CntStalled increments on each edge with Stall=1 and no Flush.
  - CntSquashed increments on each edge where a NOP is loaded due to Flush or SQUASH.
  - All three wrap modulo 2^32 and reset to 0 on RST.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package (pipeline_pkg):
  - DATA_W default.
  - NOP_WORD constant.
  - IF/ID FSM state encoding: RUN=1'b0, SQUASH=1'b1.
  - FLUSH_BUBBLES legal range constants.
- Sub-module: ifid_perf_counter, a single wrapping counter with increment enable. Instantiated three times only under IFID_PERF_CNT_EN.

Test Plan:
- Reset, then unstalled feed: InstrIn=0x2010_0005 with IncPCIn=1, next InstrIn=0x0230_8820 with IncPCIn=2.
  - Required: one cycle later InstrOut=0x20100005, IncPCOut=1, ValidOut=1; following cycle 0x02308820, IncPCOut=2.
- Stall for 3 cycles with changing InstrIn: InstrOut/IncPCOut/ValidOut stay frozen all 3 cycles. The first edge after Stall drops captures the current InstrIn.
- FLUSH_BUBBLES=1, Flush pulse with InstrIn=0xDEAD_BEEF: next InstrOut=0x00000000, ValidOut=0. The following edge captures a valid instruction; Squashing never asserts.
- FLUSH_BUBBLES=3, Flush plus Stall together, then Stall held 2 more cycles:
  - Flush wins and a NOP is loaded.
  - Squashing=1 throughout; 2 further unstalled bubbles are emitted, then ValidOut=1.
- RST asserted during SQUASH with counter=2: next edge gives state RUN, Squashing=0, ValidOut=0. The first post-reset edge loads a valid instruction.
- Under IFID_PERF_CNT_EN, run 10 valid fetches, 4 stall cycles and 1 flush with FLUSH_BUBBLES=2: CntFetched=10, CntStalled=4, CntSquashed=2.
